// File: rtl/rv32I_core_pkg.sv
// rv32I_core_pkg: shared types and constants for the multicycle RV32I control path.
package rv32I_core_pkg;
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } seq_state_t;
  localparam logic PC_SEL_PLUS4  = 1'b0;
  localparam logic PC_SEL_BRANCH = 1'b1;
  // Bit positions of the instruction-class vector produced by the decode controller
  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_B   = 2;
  localparam int CLS_LD  = 3;
  localparam int CLS_STR = 4;
  localparam int CLS_W   = 5;
  typedef logic [CLS_W-1:0] cls_t;
  function automatic logic cls_onehot(input cls_t c);
    return (c != '0) && ((c & (c - cls_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/rv32i_retire_counter.sv
// rv32i_retire_counter: wrapping count of retired instructions.
module rv32i_retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = i_inc ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) count_q <= '0;
    else count_q <= count_d;
  assign o_count = count_q;
endmodule

// File: rtl/rv32i_multicycle_sequencer.sv
// rv32i_multicycle_sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with sticky trap.
// Define RV32I_SEQ_INSTRET_EN to add the o_instret retirement counter.
module rv32i_multicycle_sequencer
  import rv32I_core_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int WORD_SIZE         = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_req,
  input  logic                         i_imem_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  input  logic                         i_invalid_instruction,
  input  logic                         i_r_type,
  input  logic                         i_i_type,
  input  logic                         i_b_type,
  input  logic                         i_ld_type,
  input  logic                         i_str_type,
  input  logic                         i_branch_taken,
  output logic                         o_dmem_req,
  output logic                         o_dmem_we,
  input  logic                         i_dmem_valid,
  output logic                         o_alu_en,
  output logic                         o_rf_we,
  output logic                         o_pc_we,
  output logic                         o_pc_sel,
`ifdef RV32I_SEQ_INSTRET_EN
  output logic [WORD_SIZE-1:0]         o_instret,
`endif
  output logic                         o_trap,
  output logic [2:0]                   o_state
);
  seq_state_t state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
  cls_t cls_q, cls_d, cls_in;
  logic imem_req, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, run;
  assign cls_in = {i_str_type, i_ld_type, i_b_type, i_i_type, i_r_type};
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cls_d    = cls_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_PLUS4;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (i_imem_valid) begin
          ir_d    = i_imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d   = cls_in;
        state_d = (i_invalid_instruction || !cls_onehot(cls_in)) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en  = 1'b1;
        pc_we   = cls_q[CLS_B];
        pc_sel  = (cls_q[CLS_B] && i_branch_taken) ? PC_SEL_BRANCH : PC_SEL_PLUS4;
        state_d = cls_q[CLS_B] ? S_FETCH :
                  (cls_q[CLS_LD] || cls_q[CLS_STR]) ? S_MEMORY :
                  (cls_q[CLS_R] || cls_q[CLS_I]) ? S_WRITEBACK : S_TRAP;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = cls_q[CLS_STR];
        pc_we    = i_dmem_valid && cls_q[CLS_STR];
        if (i_dmem_valid) state_d = cls_q[CLS_STR] ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cls_q   <= cls_d;
    end
  // Strobes are forced low while reset is held so an abandoned access fires nothing
  assign run           = !i_rst;
  assign o_imem_req    = run && imem_req;
  assign o_dmem_req    = run && dmem_req;
  assign o_dmem_we     = run && dmem_we;
  assign o_alu_en      = run && alu_en;
  assign o_rf_we       = run && rf_we;
  assign o_pc_we       = run && pc_we;
  assign o_pc_sel      = run && pc_sel;
  assign o_trap        = state_q == S_TRAP;
  assign o_state       = state_q;
  assign o_instruction = ir_q;
`ifdef RV32I_SEQ_INSTRET_EN
  rv32i_retire_counter #(.WIDTH(WORD_SIZE)) u_retire (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (o_pc_we),
    .o_count(o_instret)
  );
`endif
endmodule

// File: doc/rv32i_multicycle_sequencer.md
Name: rv32i_multicycle_sequencer

Overview:
- Main control FSM of the multicycle RV32I core.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Consumes instruction-class flags from the decode controller, plus branch outcome and memory handshakes.
- Drives the IR/PC/regfile write enables, ALU enable and memory request strobes; owns the sticky trap on illegal encodings.

Parameters:
- INSTRUCTION_WIDTH, 32, width of fetched instruction and IR.
- WORD_SIZE, 32, datapath word width (instret counter width).

Ports:
- i_clk  in  1  core clock; all state on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_imem_req  out  1  instruction fetch request; held until i_imem_valid.
- i_imem_valid  in  1  fetch data valid; may assert in the same cycle as o_imem_req.
- i_imem_data  in  INSTRUCTION_WIDTH  fetched instruction word.
- o_instruction  out  INSTRUCTION_WIDTH  IR contents, fed to the decode controller.
- i_invalid_instruction  in  1  decoder illegal flag.
- i_r_type, i_i_type, i_b_type, i_ld_type, i_str_type  in  1 each  decoder class flags.
- i_branch_taken  in  1  branch comparator result, valid in EXECUTE.
- o_dmem_req  out  1  data memory request; held until i_dmem_valid.
- o_dmem_we  out  1  1 = store, 0 = load; valid while o_dmem_req is high.
- i_dmem_valid  in  1  data memory completion.
- o_alu_en  out  1  ALU/branch adder operands are captured this cycle.
- o_rf_we  out  1  register file write.
- o_pc_we  out  1  PC update; marks instruction retirement.
- o_pc_sel  out  1  0 = PC+4, 1 = branch target; meaningful only with o_pc_we.
- o_trap  out  1  sticky illegal-instruction halt.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6-7 are unreachable and recover to FETCH.
- Reset: state=FETCH, IR=0, latched class=0, all outputs 0.
- Reset release:
  - o_imem_req goes high in the first FETCH cycle after reset release.
  - Reset asserted mid-access abandons the access immediately; no write enables fire.
- FETCH: o_imem_req=1. When i_imem_valid=1, o_ir_we (internal) loads i_imem_data into the IR and the next state is DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Latch the class flags.
  - If i_invalid_instruction=1, or the class flags are not exactly one-hot, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle), o_alu_en=1:
  - b_type: o_pc_we=1, o_pc_sel=i_branch_taken, next state FETCH.
  - ld/str: next state MEMORY.
  - r/i: next state WRITEBACK.
- MEMORY: o_dmem_req=1, o_dmem_we=str. Wait for i_dmem_valid.
  - Store: in the valid cycle, o_pc_we=1, o_pc_sel=0, next state FETCH.
  - Load: next state WRITEBACK.
- WRITEBACK (1 cycle): o_rf_we=1, o_pc_we=1, o_pc_sel=0, next state FETCH.
- TRAP: o_trap=1, all other strobes 0. Exit only via i_rst.
- Minimum latency with zero-wait memories: branch 3 cycles, R/I 4, store 4, load 5.
- o_imem_req and o_dmem_req are never high together. At most one o_pc_we pulse per instruction.
- i_imem_valid outside FETCH and i_dmem_valid outside MEMORY are ignored.

Optional Feature:
- Macro RV32I_SEQ_INSTRET_EN.
- Defined:
  - Adds output o_instret (WORD_SIZE bits).
  - Reset to 0; increments by 1 in every cycle o_pc_we=1.
  - Wraps 0xFFFFFFFF to 0; does not count in TRAP.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32I_core_pkg holds:
  - seq_state_t enum with the encodings above.
  - PC_SEL_PLUS4 = 0, PC_SEL_BRANCH = 1.
  - Class-flag index constants shared with the decode controller.
- Sub-module rv32i_retire_counter (counter plus wrap), instantiated only under RV32I_SEQ_INSTRET_EN.
- FSM, IR and class latch stay in this module.

Test Plan:
- ADD 0x002081B3, imem valid same cycle: states 0,1,2,4. o_rf_we and o_pc_we both high in cycle 4, o_pc_sel=0. Total 4 cycles.
- BEQ, i_branch_taken=1: o_pc_we=1 with o_pc_sel=1 in the EXECUTE cycle. o_rf_we and o_dmem_req never assert. Back in FETCH at cycle 4.
- LW, i_dmem_valid delayed 3 cycles: o_dmem_req=1 and o_dmem_we=0 for 4 cycles, then one WRITEBACK cycle with o_rf_we=1. Exactly one o_pc_we pulse.
- SW, dmem valid same cycle: o_dmem_we=1, o_pc_we=1 in the MEMORY cycle, o_rf_we stays 0.
- Instruction 0xFFFFFFFF (invalid flag set): TRAP after DECODE, o_trap stays 1 for 100 cycles, no requests. Asserting i_rst returns to FETCH with o_trap=0.
- i_rst asserted while o_dmem_req=1, then released: outputs 0 during reset, restart in FETCH. With RV32I_SEQ_INSTRET_EN, o_instret=0 after reset and equals N after N retired instructions.
